// File: rtl/aes_pkg.sv
// AES helpers shared by the encrypt and decrypt datapaths:
// GF(2^8) multipliers, state widths and the iterative-stage FSM encoding.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } imc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul09(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/inv_mix_columns_iter_if.sv
// Valid/ready bundle between the decrypt round and the InvMixColumns stage.
// master drives the input side and accepts results; slave is the stage.
interface inv_mix_columns_iter_if;
  import aes_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AES_STATE_W-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_STATE_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns on one 32-bit column.
// Row-0 byte sits in the MSB.
module inv_mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] col_i,
  output logic [AES_COL_W-1:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;

  assign col_o[31:24] = gmul0e(a0) ^ gmul0b(a1)
                      ^ gmul0d(a2) ^ gmul09(a3);
  assign col_o[23:16] = gmul09(a0) ^ gmul0e(a1)
                      ^ gmul0b(a2) ^ gmul0d(a3);
  assign col_o[15:8]  = gmul0d(a0) ^ gmul09(a1)
                      ^ gmul0e(a2) ^ gmul0b(a3);
  assign col_o[7:0]   = gmul0b(a0) ^ gmul0d(a1)
                      ^ gmul09(a2) ^ gmul0e(a3);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns, COLS_PER_CYC columns per clock.
// Define INV_MIX_ZERO_OUT_EN to blank out_data while out_valid is low.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYC = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  inv_mix_columns_iter_if.slave bus
);

  if (!(COLS_PER_CYC == 1 ||
        COLS_PER_CYC == 2 ||
        COLS_PER_CYC == 4)) begin : g_bad_cfg
    $error("COLS_PER_CYC must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYC);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYC);

  imc_state_e                  state_q, state_d;
  logic [1:0]                  col_idx_q, col_idx_d;
  logic [3:0][AES_COL_W-1:0]   work_q, work_d;

  logic [COLS_PER_CYC-1:0][1:0]           col_sel;
  logic [COLS_PER_CYC-1:0][AES_COL_W-1:0] col_in;
  logic [COLS_PER_CYC-1:0][AES_COL_W-1:0] col_out;

  logic acc;
  logic last;

  // column c lives at packed index 3-c, i.e. ~c for a 2-bit index
  for (genvar k = 0; k < COLS_PER_CYC; k++) begin : g_col
    assign col_sel[k] = col_idx_q + 2'(k);
    assign col_in[k]  = work_q[~col_sel[k]];
    inv_mix_single_column u_col (
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  assign acc  = (state_q == IDLE) && bus.in_valid;
  assign last = (col_idx_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    work_d    = work_q;
    col_idx_d = col_idx_q;
    if (acc) begin
      work_d    = bus.in_data;
      col_idx_d = 2'd0;
    end else if (state_q == BUSY) begin
      for (int k = 0; k < COLS_PER_CYC; k++) begin
        work_d[~col_sel[k]] = col_out[k];
      end
      col_idx_d = col_idx_q + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q    <= '0;
      col_idx_q <= 2'd0;
    end else begin
      work_q    <= work_d;
      col_idx_q <= col_idx_d;
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
`ifdef INV_MIX_ZERO_OUT_EN
    bus.out_data  = bus.out_valid ? work_q : '0;
`else
    bus.out_data  = work_q;
`endif
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter at COLS_PER_CYC 1, 2 and 4.
// Round trip uses an independent encrypt-side MixColumns model.
module tb_inv_mix_columns_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  inv_mix_columns_iter_if b1 ();
  inv_mix_columns_iter_if b2 ();
  inv_mix_columns_iter_if b4 ();

  inv_mix_columns_iter #(.COLS_PER_CYC(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  inv_mix_columns_iter #(.COLS_PER_CYC(2)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));
  inv_mix_columns_iter #(.COLS_PER_CYC(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave));

  localparam logic [127:0] V_IN  =
    128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_OUT =
    128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_C6  =
    128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  function automatic logic [7:0] x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_fwd(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      r[127-32*c -: 32] = {
        x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
        x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
    end
    return r;
  endfunction

  task automatic run1(input logic [127:0] d,
                      output logic [127:0] r, output int lat);
    b1.in_valid = 1'b1;
    b1.in_data  = d;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b1.out_valid) begin lat = n; break; end
    end
    r = b1.out_data;
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
  endtask

  task automatic run2(input logic [127:0] d,
                      output logic [127:0] r, output int lat);
    b2.in_valid = 1'b1;
    b2.in_data  = d;
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b2.out_valid) begin lat = n; break; end
    end
    r = b2.out_data;
    b2.out_ready = 1'b1;
    @(posedge clk); #1;
    b2.out_ready = 1'b0;
  endtask

  task automatic run4(input logic [127:0] d,
                      output logic [127:0] r, output int lat);
    b4.in_valid = 1'b1;
    b4.in_data  = d;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b4.out_valid) begin lat = n; break; end
    end
    r = b4.out_data;
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 ||
        b1.out_data !== 128'h0) begin
      bad++;
      $display("FAIL reset1 rdy=%b vld=%b data=%h want 1 0 0",
               b1.in_ready, b1.out_valid, b1.out_data);
    end
    total++;
    if (b2.in_ready !== 1'b1 || b4.in_ready !== 1'b1 ||
        b2.out_valid !== 1'b0 || b4.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset24 rdy=%b%b vld=%b%b want 11 00",
               b2.in_ready, b4.in_ready, b2.out_valid, b4.out_valid);
    end
  endtask

  task automatic test_vector1();
    int lat;
    b1.in_valid = 1'b1;
    b1.in_data  = V_IN;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    total++;
    if (b1.in_ready !== 1'b0 || b1.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL accept rdy=%b vld=%b want 0 0",
               b1.in_ready, b1.out_valid);
    end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (b1.out_valid) begin lat = n; break; end
`ifdef INV_MIX_ZERO_OUT_EN
      total++;
      if (b1.out_data !== 128'h0) begin
        bad++;
        $display("FAIL zero_out edge=%0d got=%h want 0",
                 n, b1.out_data);
      end
`else
      if (n == 1) begin
        total++;
        if (b1.out_data !== {V_OUT[127:96], V_IN[95:0]}) begin
          bad++;
          $display("FAIL partial got=%h want %h", b1.out_data,
                   {V_OUT[127:96], V_IN[95:0]});
        end
      end
`endif
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL latency1 got=%0d want 4", lat);
    end
    total++;
    if (b1.out_data !== V_OUT) begin
      bad++;
      $display("FAIL vector1 got=%h want %h", b1.out_data, V_OUT);
    end
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
    total++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release vld=%b rdy=%b want 0 1",
               b1.out_valid, b1.in_ready);
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig, got;
    int lat;
    int errs = 0;
    run1(V_C6, got, lat);
    total++;
    if (got !== V_C6 || lat !== 4) begin
      bad++;
      $display("FAIL c6 got=%h lat=%0d want %h 4", got, lat, V_C6);
    end
    for (int i = 0; i < 200; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      run1(mix_fwd(orig), got, lat);
      if (got !== orig && errs < 3) begin
        $display("FAIL roundtrip i=%0d got=%h want %h", i, got, orig);
      end
      if (got !== orig || lat !== 4) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL roundtrip_count got=%0d errors want 0", errs);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] got;
    int lat;
    b1.in_valid = 1'b1;
    b1.in_data  = V_IN;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    b1.in_valid = 1'b1;
    b1.in_data  = V_C6;
    for (int n = 0; n < 7; n++) begin
      @(posedge clk); #1;
      total++;
      if (b1.out_valid !== 1'b1 || b1.in_ready !== 1'b0 ||
          b1.out_data !== V_OUT) begin
        bad++;
        $display("FAIL hold n=%0d vld=%b rdy=%b data=%h want 1 0 %h",
                 n, b1.out_valid, b1.in_ready, b1.out_data, V_OUT);
      end
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
    total++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release vld=%b rdy=%b want 0 1",
               b1.out_valid, b1.in_ready);
    end
    run1(V_IN, got, lat);
    total++;
    if (got !== V_OUT || lat !== 4) begin
      bad++;
      $display("FAIL bp_next got=%h lat=%0d want %h 4", got, lat, V_OUT);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] got;
    int lat;
    b1.in_valid = 1'b1;
    b1.in_data  = V_IN;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 ||
        b1.out_data !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset vld=%b rdy=%b data=%h want 0 1 0",
               b1.out_valid, b1.in_ready, b1.out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run1(V_IN, got, lat);
    total++;
    if (got !== V_OUT || lat !== 4) begin
      bad++;
      $display("FAIL after_reset got=%h lat=%0d want %h 4",
               got, lat, V_OUT);
    end
  endtask

  task automatic test_cols_sweep();
    logic [127:0] got;
    int lat;
    run2(V_IN, got, lat);
    total++;
    if (got !== V_OUT || lat !== 2) begin
      bad++;
      $display("FAIL cols2 got=%h lat=%0d want %h 2", got, lat, V_OUT);
    end
    run4(V_IN, got, lat);
    total++;
    if (got !== V_OUT || lat !== 1) begin
      bad++;
      $display("FAIL cols4 got=%h lat=%0d want %h 1", got, lat, V_OUT);
    end
    run2(V_C6, got, lat);
    total++;
    if (got !== V_C6) begin
      bad++;
      $display("FAIL cols2_c6 got=%h want %h", got, V_C6);
    end
    run4(mix_fwd(V_OUT), got, lat);
    total++;
    if (got !== V_OUT) begin
      bad++;
      $display("FAIL cols4_rt got=%h want %h", got, V_OUT);
    end
  endtask

  initial begin
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.out_ready = 1'b0;
    b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_vector1();
    test_round_trip();
    test_backpressure();
    test_reset_mid_busy();
    test_cols_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
